// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and encodings for the iterative MULT/DIV controller.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;
  localparam logic SEL_HI  = 1'b0;
  localparam logic SEL_LO  = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration, purely combinational.
module muldiv_step
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             op_i,
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] shreg_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] shreg_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    acc_o   = '0;
    shreg_o = '0;
    sum     = acc_i + {1'b0, (shreg_i[0] ? operand_i : {WIDTH{1'b0}})};
    shifted = {acc_i[WIDTH-1:0], shreg_i[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, operand_i};
    if (op_i == OP_MULT) begin
      // {acc,mplr} >> 1 after the conditional add keeps the product exact
      acc_o   = {1'b0, sum[WIDTH:1]};
      shreg_o = {sum[0], shreg_i[WIDTH-1:1]};
    end else if (!diff[WIDTH+1]) begin
      acc_o   = diff[WIDTH:0];
      shreg_o = {shreg_i[WIDTH-2:0], 1'b1};
    end else begin
      acc_o   = shifted;
      shreg_o = {shreg_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/DIV sequencer owning HI/LO; serves MFHI/MFLO reads and stalls.
// Optional signed operation is enabled by defining MULDIV_SIGNED_EN.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  muldiv_state_t    state_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] opnd_q;
  logic             bzero_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] cap_a, cap_b;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [2*WIDTH-1:0] prod;
  logic             step_op;

  assign step_op = (state_q == DIV) ? OP_DIV : OP_MULT;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_i      (step_op),
    .acc_i     (acc_q),
    .shreg_i   (shreg_q),
    .operand_i (opnd_q),
    .acc_o     (acc_d),
    .shreg_o   (shreg_d)
  );

`ifdef MULDIV_SIGNED_EN
  logic a_sgn, b_sgn;
  logic neg_q, a_neg_q;

  // Signed operands run the unsigned core on magnitudes
  always_comb begin
    a_sgn = signed_op & a[WIDTH-1];
    b_sgn = signed_op & b[WIDTH-1];
    cap_a = a_sgn ? -a : a;
    cap_b = b_sgn ? -b : b;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      neg_q   <= 1'b0;
      a_neg_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      neg_q   <= a_sgn ^ b_sgn;
      a_neg_q <= a_sgn;
    end
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign cap_a = a;
  assign cap_b = b;
`endif

  // Commit value built from the final iteration's step outputs
  always_comb begin
    prod   = {acc_d[WIDTH-1:0], shreg_d};
    res_hi = '0;
    res_lo = '0;
    if (state_q == MUL) begin
`ifdef MULDIV_SIGNED_EN
      if (neg_q) prod = -prod;
`endif
      {res_hi, res_lo} = prod;
    end else if (!bzero_q) begin
      res_hi = acc_d[WIDTH-1:0];
      res_lo = shreg_d;
`ifdef MULDIV_SIGNED_EN
      if (neg_q)   res_lo = -res_lo;
      if (a_neg_q) res_hi = -res_hi;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      shreg_q <= '0;
      opnd_q  <= '0;
      bzero_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= (op == OP_DIV) ? DIV : MUL;
            busy_q  <= 1'b1;
            count_q <= '0;
            acc_q   <= '0;
            shreg_q <= (op == OP_DIV) ? cap_a : cap_b;
            opnd_q  <= (op == OP_DIV) ? cap_b : cap_a;
            bzero_q <= (b == '0);
          end
        end
        MUL, DIV: begin
          acc_q   <= acc_d;
          shreg_q <= shreg_d;
          count_q <= count_q + CNT_W'(1);
          if (count_q == CNT_W'(WIDTH - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            hi_q    <= res_hi;
            lo_q    <= res_lo;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall   = (rd_req || start) && (state_q != IDLE);
  assign rd_data = (rd_sel == SEL_LO) ? lo_q : hi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: vector table plus stall/ignore and reset-abort sequences.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int unsigned W = 32;
  localparam int LAT = 33;

  logic         clock, reset, start, op, signed_op, rd_req, rd_sel;
  logic [W-1:0] a, b, rd_data, hi, lo;
  logic         busy, done, stall;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .signed_op(signed_op),
    .a(a), .b(b), .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         op;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op, scramble a/b afterwards, and watch 40 samples
  task automatic run_op(input vec_t v, output int done_at, output int busy_cnt, output int done_cnt);
    @(negedge clock);
    start = 1'b1; op = v.op; signed_op = v.sgn; a = v.a; b = v.b;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom;
    done_at = -1; busy_cnt = 0; done_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c < 40) @(negedge clock);
    end
  endtask

  initial begin
    int d_at, b_cnt, d_cnt, stall_bad;
    logic [W-1:0] p_lo;
    vec_t v;

    clock = 1'b0; reset = 1'b1; start = 1'b0; op = OP_MULT; signed_op = 1'b0;
    a = '0; b = '0; rd_req = 1'b0; rd_sel = SEL_HI;

    vecs.push_back('{OP_MULT, 1'b0, 32'd7,          32'd6,          32'd0,          32'd42});
    vecs.push_back('{OP_MULT, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001});
    vecs.push_back('{OP_DIV,  1'b0, 32'd100,        32'd7,          32'd2,          32'd14});
    vecs.push_back('{OP_DIV,  1'b0, 32'd5,          32'd0,          32'd0,          32'd0});
    vecs.push_back('{OP_MULT, 1'b0, 32'h1234_5678,  32'h10,         32'd1,          32'h2345_6780});
    vecs.push_back('{OP_DIV,  1'b0, 32'hFFFF_FFFF,  32'h10,         32'hF,          32'h0FFF_FFFF});
    vecs.push_back('{OP_DIV,  1'b0, 32'd3,          32'd10,         32'd3,          32'd0});
    vecs.push_back('{OP_MULT, 1'b0, 32'h8000_0000,  32'd2,          32'd1,          32'd0});
`ifdef MULDIV_SIGNED_EN
    vecs.push_back('{OP_DIV,  1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD});
    vecs.push_back('{OP_MULT, 1'b1, 32'hFFFF_FFFD,  32'd4,          32'hFFFF_FFFF,  32'hFFFF_FFF4});
    vecs.push_back('{OP_DIV,  1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000});
`else
    vecs.push_back('{OP_DIV,  1'b1, 32'hFFFF_FFF9,  32'd2,          32'd1,          32'h7FFF_FFFC});
    vecs.push_back('{OP_MULT, 1'b1, 32'hFFFF_FFFD,  32'd4,          32'd3,          32'hFFFF_FFF4});
`endif

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    foreach (vecs[i]) begin
      v = vecs[i];
      run_op(v, d_at, b_cnt, d_cnt);
      chk($sformatf("v%0d_done_at", i), 64'(d_at), 64'(LAT));
      chk($sformatf("v%0d_busy_cycles", i), 64'(b_cnt), 64'(LAT));
      chk($sformatf("v%0d_done_pulses", i), 64'(d_cnt), 64'd1);
      chk($sformatf("v%0d_hi", i), 64'(hi), 64'(v.hi));
      chk($sformatf("v%0d_lo", i), 64'(lo), 64'(v.lo));
      rd_req = 1'b1; rd_sel = SEL_LO; #1;
      chk($sformatf("v%0d_rd_lo", i), 64'(rd_data), 64'(v.lo));
      chk($sformatf("v%0d_idle_stall", i), 64'(stall), 64'd0);
      rd_sel = SEL_HI; #1;
      chk($sformatf("v%0d_rd_hi", i), 64'(rd_data), 64'(v.hi));
      rd_req = 1'b0;
    end

    // Start + read together in IDLE, late read while busy, ignored second start
    p_lo = vecs[vecs.size()-1].lo;
    @(negedge clock);
    rd_req = 1'b1; rd_sel = SEL_LO; start = 1'b1; op = OP_MULT; signed_op = 1'b0;
    a = 32'd3; b = 32'd5; #1;
    chk("idle_start_rd_stall", 64'(stall), 64'd0);
    chk("idle_start_rd_data", 64'(rd_data), 64'(p_lo));
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; rd_req = 1'b0;
    stall_bad = 0;
    for (int c = 1; c <= 36; c++) begin
      if (c == 5) begin
        rd_req = 1'b1; rd_sel = SEL_LO;
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd100;
      end
      if (c == 8) start = 1'b0;
      #1;
      if (c >= 5 && c <= LAT && stall !== 1'b1) stall_bad++;
      if (c == 10) chk("busy_rd_old_lo", 64'(rd_data), 64'(p_lo));
      if (c == LAT + 1) begin
        chk("post_done_stall", 64'(stall), 64'd0);
        chk("post_done_rd_lo", 64'(rd_data), 64'd15);
      end
      if (c < 36) @(negedge clock);
    end
    chk("busy_stall_cycles_bad", 64'(stall_bad), 64'd0);
    chk("second_start_ignored_busy", 64'(busy), 64'd0);
    chk("second_start_hi", 64'(hi), 64'd0);
    chk("second_start_lo", 64'(lo), 64'd15);
    rd_req = 1'b0;

    // Reset during DIV iteration 10 aborts without a done pulse
    @(negedge clock);
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    d_cnt = 0; b_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done) d_cnt++;
      if (busy) b_cnt++;
    end
    chk("abort_no_done", 64'(d_cnt), 64'd0);
    chk("abort_stays_idle", 64'(b_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
